// File: rtl/demux1_2_latch_if.sv
// Write-side request/acknowledge bundle for the 1:2 destination demux.
interface demux1_2_latch_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             ctrl;
  logic             wr_req;
  logic             wr_ack;
  logic             busy;

  modport master (
    output data_in, ctrl, wr_req,
    input  wr_ack, busy
  );

  modport slave (
    input  data_in, ctrl, wr_req,
    output wr_ack, busy
  );
endinterface

// File: rtl/demux1_2_latch.sv
// Steers a bus value into one of two holding registers over a 4-phase handshake,
// tracking per-destination unread (valid) and overwrite (ovf) status.
module demux1_2_latch #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux1_2_latch_if.slave      wr_if,
  output logic [WIDTH-1:0]     output0,
  output logic [WIDTH-1:0]     output1,
  output logic                 valid0,
  output logic                 valid1,
  input  logic                 rd0,
  input  logic                 rd1,
  output logic                 ovf0,
  output logic                 ovf1,
  input  logic                 ovf_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_sel_q, hold_sel_d;
  logic             wr_ack_q, wr_ack_d;
  logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
  logic             valid0_q, valid0_d, valid1_q, valid1_d;
  logic             ovf0_q, ovf0_d, ovf1_q, ovf1_d;

  // Next-state logic: read strobes and ovf_clr apply first so a same-edge write/set wins.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;
    wr_ack_d    = wr_ack_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    valid0_d    = valid0_q & ~rd0;
    valid1_d    = valid1_q & ~rd1;
    ovf0_d      = ovf0_q & ~ovf_clr;
    ovf1_d      = ovf1_q & ~ovf_clr;

    unique case (state_q)
      IDLE: begin
        if (wr_if.wr_req) begin
          hold_data_d = wr_if.data_in;
          hold_sel_d  = wr_if.ctrl;
          state_d     = LATCH;
        end
      end
      LATCH: begin
        wr_ack_d = 1'b1;
        state_d  = ACK;
        if (hold_sel_q) begin
          out1_d   = hold_data_q;
          valid1_d = 1'b1;
          if (valid1_q && !rd1) ovf1_d = 1'b1;
        end else begin
          out0_d   = hold_data_q;
          valid0_d = 1'b1;
          if (valid0_q && !rd0) ovf0_d = 1'b1;
        end
      end
      ACK: begin
        if (!wr_if.wr_req) begin
          wr_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        wr_ack_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_sel_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      ovf0_q      <= 1'b0;
      ovf1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
      wr_ack_q    <= wr_ack_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      valid0_q    <= valid0_d;
      valid1_q    <= valid1_d;
      ovf0_q      <= ovf0_d;
      ovf1_q      <= ovf1_d;
    end
  end

  assign wr_if.wr_ack = wr_ack_q;
  assign wr_if.busy   = (state_q != IDLE);
  assign output0      = out0_q;
  assign output1      = out1_q;
  assign valid0       = valid0_q;
  assign valid1       = valid1_q;
  assign ovf0         = ovf0_q;
  assign ovf1         = ovf1_q;

endmodule

// File: tb/tb_demux1_2_latch.sv
// Self-checking bench for demux1_2_latch: directed scenarios followed by
// randomized transfers, compared against a transaction-level reference model.
module tb_demux1_2_latch;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux1_2_latch_if #(.WIDTH(WIDTH)) wr_if ();

  logic [WIDTH-1:0] output0, output1;
  logic valid0, valid1, rd0, rd1, ovf0, ovf1, ovf_clr;

  demux1_2_latch #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_if   (wr_if.slave),
    .output0 (output0),
    .output1 (output1),
    .valid0  (valid0),
    .valid1  (valid1),
    .rd0     (rd0),
    .rd1     (rd1),
    .ovf0    (ovf0),
    .ovf1    (ovf1),
    .ovf_clr (ovf_clr)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: what each destination should hold and report.
  logic [WIDTH-1:0] m_out [2];
  bit               m_val [2];
  bit               m_ovf [2];
  bit               m_ack;
  bit               m_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":output0"}, 32'(output0), 32'(m_out[0]));
    chk({tag, ":output1"}, 32'(output1), 32'(m_out[1]));
    chk({tag, ":valid0"},  32'(valid0),  32'(m_val[0]));
    chk({tag, ":valid1"},  32'(valid1),  32'(m_val[1]));
    chk({tag, ":ovf0"},    32'(ovf0),    32'(m_ovf[0]));
    chk({tag, ":ovf1"},    32'(ovf1),    32'(m_ovf[1]));
    chk({tag, ":wr_ack"},  32'(wr_if.wr_ack), 32'(m_ack));
    chk({tag, ":busy"},    32'(wr_if.busy),   32'(m_busy));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = '0;
      m_val[i] = 1'b0;
      m_ovf[i] = 1'b0;
    end
    m_ack  = 1'b0;
    m_busy = 1'b0;
  endtask

  // One clock edge: apply strobes, predict the destinations, advance, check.
  task automatic step(input string tag, input bit r0, input bit r1, input bit clr,
                      input bit wr, input bit sel, input logic [WIDTH-1:0] d,
                      input bit ack, input bit busy_e);
    bit rr;
    bit setv;
    rd0     = r0;
    rd1     = r1;
    ovf_clr = clr;
    for (int i = 0; i < 2; i++) begin
      rr   = (i == 0) ? r0 : r1;
      setv = wr && (int'(sel) == i) && m_val[i] && !rr;
      if (wr && int'(sel) == i) begin
        m_out[i] = d;
        m_val[i] = 1'b1;
      end else if (rr) begin
        m_val[i] = 1'b0;
      end
      m_ovf[i] = setv | (m_ovf[i] & ~clr);
    end
    m_ack  = ack;
    m_busy = busy_e;
    @(posedge clk);
    #1;
    rd0     = 1'b0;
    rd1     = 1'b0;
    ovf_clr = 1'b0;
    check_all(tag);
  endtask

  // Full transfer from IDLE back to IDLE; inputs are scrambled after capture.
  task automatic write_txn(input string tag, input logic [WIDTH-1:0] d, input bit sel,
                           input logic [WIDTH-1:0] scr_d, input bit scr_c,
                           input int hold, input bit drop_early,
                           input bit lr0, input bit lr1, input bit lclr);
    wr_if.data_in = d;
    wr_if.ctrl    = sel;
    wr_if.wr_req  = 1'b1;
    step({tag, "/cap"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    wr_if.data_in = scr_d;
    wr_if.ctrl    = scr_c;
    if (drop_early) wr_if.wr_req = 1'b0;
    step({tag, "/latch"}, lr0, lr1, lclr, 1'b1, sel, d, 1'b1, 1'b1);
    if (!drop_early) begin
      for (int h = 0; h < hold; h++)
        step({tag, "/ack"}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b1, 1'b1);
      wr_if.wr_req = 1'b0;
    end
    step({tag, "/exit"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    wr_if.data_in = '0;
    wr_if.ctrl    = 1'b0;
    wr_if.wr_req  = 1'b0;
    rd0           = 1'b0;
    rd1           = 1'b0;
    ovf_clr       = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    write_txn("w3C", 8'h3C, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    write_txn("wA5", 8'hA5, 1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    write_txn("w11_ovf", 8'h11, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ovf_clr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    write_txn("w77_rd0", 8'h77, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rd1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    write_txn("w42_scr", 8'h42, 1'b0, 8'hFF, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    write_txn("w_drop", 8'h5A, 1'b1, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    write_txn("w_setclr", 8'h9E, 1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset while in ACK with output1 holding A5.
    wr_if.data_in = 8'hA5;
    wr_if.ctrl    = 1'b1;
    wr_if.wr_req  = 1'b1;
    step("rstA5/cap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step("rstA5/latch", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    #2;
    rst_n        = 1'b0;
    wr_if.wr_req = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_release");
    write_txn("w01", 8'h01, 1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0, 1: write_txn("rnd_wr", 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: step("rnd_idle", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux1_2_latch.md
Name: demux1_2_latch

Overview:
- Write-side counterpart of the 8-bit 2:1 source-select mux: steers one 8-bit bus value into one of two destination holding registers, selected by `ctrl`.
- A 4-phase req/ack handshake transfers each value.
- Per-destination valid flags are cleared by consumer read strobes.
- Sticky overflow flags record writes that land on an unread value.
- Sits between the internal data bus and two downstream consumers, e.g. the A/B operand latches feeding the ALU input mux.

Parameters:
- WIDTH, 8, data bus and holding-register width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  bus value to be written.
- ctrl  input  1  destination select: 0 -> output0, 1 -> output1; sampled with data_in.
- wr_req  input  1  write request, 4-phase; held high until wr_ack seen.
- wr_ack  output  1  registered acknowledge.
- busy  output  1  high whenever FSM not in IDLE.
- output0  output  WIDTH  destination-0 holding register.
- output1  output  WIDTH  destination-1 holding register.
- valid0  output  1  output0 holds unread data.
- valid1  output  1  output1 holds unread data.
- rd0  input  1  single-cycle strobe: consumer 0 has taken output0.
- rd1  input  1  single-cycle strobe: consumer 1 has taken output1.
- ovf0  output  1  sticky: output0 overwritten while valid0=1.
- ovf1  output  1  sticky: output1 overwritten while valid1=1.
- ovf_clr  input  1  clears ovf0 and ovf1.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): FSM=IDLE, all outputs 0 (wr_ack, busy, output0/1, valid0/1, ovf0/1), internal hold registers 0. Release takes effect at first rising edge with rst_n=1.
- FSM states: IDLE, LATCH, ACK.
- IDLE:
  - wr_req=1 at edge k: capture data_in into hold_data and ctrl into hold_sel; go to LATCH.
  - Otherwise stay in IDLE.
- LATCH (edge k+1):
  - Write hold_data into the output selected by hold_sel.
  - Set the selected valid flag; set wr_ack=1; go to ACK.
  - Unselected output and its flags are unchanged.
  - Latency: data, valid and wr_ack all visible together in the cycle after edge k+1.
- ACK:
  - Hold wr_ack=1 while wr_req=1.
  - First edge sampling wr_req=0: wr_ack=0, go to IDLE.
  - Next request is accepted no earlier than the following edge, so the minimum transfer is 3 cycles from wr_req rise to idle.
- busy = (state != IDLE); combinational from state register.
- data_in and ctrl changes after the capture edge are ignored for that transfer.
- wr_req dropping during LATCH is legal: the write completes, ACK is entered, and the ACK exit follows on the next edge.
- Valid flags:
  - rdN=1 at an edge clears validN.
  - LATCH write to N at the same edge as rdN: validN ends at 1 (write wins) and ovfN is not set.
- Overflow:
  - LATCH write to N with validN=1 and rdN=0 at that edge sets ovfN.
  - ovfN is sticky until ovf_clr=1 or reset.
  - Set and ovf_clr at the same edge: set wins.
- rdN while validN=0: no effect and no error.
- Reset mid-transfer (LATCH/ACK): transfer is abandoned, outputs zeroed, wr_ack low immediately (asynchronous).

Test Plan:
- Reset, then wr_req=1 with data_in=8'h3C, ctrl=0 -> after 2nd edge: output0=8'h3C, valid0=1, wr_ack=1, busy=1. output1=0, valid1=0.
- Drop wr_req -> next edge wr_ack=0, busy=0, IDLE. Then write 8'hA5 with ctrl=1 -> output1=8'hA5, valid1=1, output0 still 8'h3C.
- Write 8'h11 to dest 0 while valid0=1, no rd0 -> output0=8'h11, ovf0=1. Pulse ovf_clr -> ovf0=0.
- rd0 pulse on the same edge as a LATCH write of 8'h77 to dest 0 -> output0=8'h77, valid0=1, ovf0 stays 0. A lone rd1 pulse -> valid1=0.
- Change data_in to 8'hFF and ctrl to 1 one cycle after the capture of 8'h42/ctrl=0 -> output0=8'h42, output1 unchanged.
- Assert rst_n=0 mid-edge during ACK with output1=8'hA5, valid1=1 -> all outputs 0 without waiting for a clock edge. Release, then a fresh write of 8'h01 to dest 1 completes normally.
